// File: rtl/matrix_arb_pkg.sv
// Shared constants for the matrix-op arbiter: geometry, datapath op-select codes and the in-flight tag.
package matrix_arb_pkg;

    localparam int unsigned MAT_DIM = 4;
    localparam int unsigned ELEM_W  = 16;
    localparam int unsigned DATA_W  = MAT_DIM * MAT_DIM * ELEM_W;
    localparam int unsigned RES_W   = 512;
    localparam int unsigned SEL_W   = 2;

    localparam logic [SEL_W-1:0] SEL_PASS      = 2'b00;
    localparam logic [SEL_W-1:0] SEL_TRANSPOSE = 2'b01;
    localparam logic [SEL_W-1:0] SEL_ACCUM     = 2'b10;
    localparam logic [SEL_W-1:0] SEL_TRANS_ACC = 2'b11;

    // Sized for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO; head shows the oldest entry whenever count is non-zero.
module result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/matrix_op_arbiter.sv
// Round-robin arbiter sharing one matrix datapath among NUM_REQ requesters, with credit-protected result FIFO.
// Optional per-requester grant counters on stat_grants when MATRIX_ARB_STATS_EN is defined.
module matrix_op_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = matrix_arb_pkg::DATA_W,
    parameter int unsigned RES_W     = matrix_arb_pkg::RES_W,
    parameter int unsigned SEL_W     = matrix_arb_pkg::SEL_W,
    parameter int unsigned DP_LAT    = 2,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*SEL_W-1:0]     req_sel,
    output logic [DATA_W-1:0]            dp_dataa,
    output logic [SEL_W-1:0]             dp_in_select,
    output logic                         dp_valid,
    input  logic [RES_W-1:0]             dp_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [RES_W-1:0]             rsp_data
`ifdef MATRIX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]        stat_grants
`endif
);

    import matrix_arb_pkg::*;

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CRW = $clog2(RES_DEPTH + 1);

    logic [IDW-1:0]  rr;
    logic [IDW-1:0]  grant;
    logic            found;
    int unsigned     scan_idx;
    logic [CRW-1:0]  credits;
    logic            issue;
    logic            pop;
    tag_t            tag_q [DP_LAT];
    logic            retire;
    logic [IDW-1:0]  retire_id;
    logic [CRW-1:0]  fifo_count;
    logic [IDW+RES_W-1:0] fifo_head;

    // First valid requester at or after rr, wrapping modulo NUM_REQ.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr) + k) % NUM_REQ;
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                grant = IDW'(scan_idx);
            end
        end
    end

    assign issue     = found && (credits != '0);
    assign req_ready = issue ? (NUM_REQ'(1) << grant) : '0;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr           <= '0;
            dp_valid     <= 1'b0;
            dp_dataa     <= '0;
            dp_in_select <= '0;
        end else begin
            dp_valid <= issue;
            if (issue) begin
                dp_dataa     <= req_data[grant*DATA_W +: DATA_W];
                dp_in_select <= req_sel[grant*SEL_W +: SEL_W];
                rr           <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    // Credits cover both in-flight ops and buffered results, so the FIFO cannot overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= CRW'(RES_DEPTH);
        end else if (issue && !pop) begin
            credits <= credits - 1'b1;
        end else if (!issue && pop) begin
            credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DP_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: issue, id: TAG_ID_W'(grant)};
            for (int unsigned i = 1; i < DP_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign retire    = tag_q[DP_LAT-1].valid;
    assign retire_id = tag_q[DP_LAT-1].id[IDW-1:0];

    result_fifo #(
        .WIDTH (IDW + RES_W),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (retire),
        .push_data ({retire_id, dp_result}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign rsp_id   = fifo_head[IDW+RES_W-1:RES_W];
    assign rsp_data = fifo_head[RES_W-1:0];

`ifdef MATRIX_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && stat_grants[i*16 +: 16] != 16'hFFFF)
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule
